hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Generates per-stage stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Its EX_stall output drives the ID/EX register hold input directly.
- Handles the post-reset boot flush, load-use bubbles, taken branch/jump redirects, and data-memory wait states with a watchdog timeout.
- Keeps saturating performance counters for stall cycles and redirects.

---
 rtl/core_pkg.sv | 78 +++++++
 rtl/hazard_sat_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, the zero
// register index and a bundle of per-stage stall/flush/redirect controls.
package core_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic pc_redirect;
        logic halted;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_IDLE = '0;

    // Hold PC and flush every pipeline register while the core boots.
    function automatic stage_ctrl_t ctrl_boot();
        stage_ctrl_t c;
        c              = CTRL_IDLE;
        c.pc_stall     = 1'b1;
        c.if_id_flush  = 1'b1;
        c.id_ex_flush  = 1'b1;
        c.ex_mem_flush = 1'b1;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

    // Freeze everything up to EX/MEM and drain a bubble into MEM/WB.
    function automatic stage_ctrl_t ctrl_mem_stall();
        stage_ctrl_t c;
        c              = CTRL_IDLE;
        c.pc_stall     = 1'b1;
        c.if_id_stall  = 1'b1;
        c.ex_stall     = 1'b1;
        c.ex_mem_stall = 1'b1;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

    function automatic stage_ctrl_t ctrl_halt();
        stage_ctrl_t c;
        c        = ctrl_mem_stall();
        c.halted = 1'b1;
        return c;
    endfunction

    function automatic stage_ctrl_t ctrl_redirect();
        stage_ctrl_t c;
        c             = CTRL_IDLE;
        c.pc_redirect = 1'b1;
        c.if_id_flush = 1'b1;
        c.id_ex_flush = 1'b1;
        return c;
    endfunction

    function automatic stage_ctrl_t ctrl_bubble();
        stage_ctrl_t c;
        c             = CTRL_IDLE;
        c.pc_stall    = 1'b1;
        c.if_id_stall = 1'b1;
        c.id_ex_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module hazard_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: boot flush, load-use bubbles,
// branch redirects and data-memory wait states with a watchdog halt.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_use_rs1,
    input  logic        ID_use_rs2,
    input  logic        ID_EX_memread,
    input  logic [4:0]  ID_EX_rd,
    input  logic        EX_take,
    input  logic        MEM_req,
    input  logic        dmem_ready,
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        IF_ID_flush,
    output logic        EX_stall,
    output logic        ID_EX_flush,
    output logic        EX_MEM_stall,
    output logic        EX_MEM_flush,
    output logic        MEM_WB_flush,
    output logic        pc_redirect,
    output logic        halted,
    output logic        mem_timeout_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count
);

    localparam int BW = $clog2(BOOT_CYCLES) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES - 1);
    localparam logic [BW-1:0] BOOT_ONE  = BW'(1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [BW-1:0] boot_cnt_q;
    logic [BW-1:0] boot_cnt_d;
    logic [WW-1:0] wait_cnt_q;
    logic [WW-1:0] wait_cnt_d;
    logic          err_q;
    logic          err_d;

    logic          mem_stall;
    logic          rs1_hit;
    logic          rs2_hit;
    logic          load_use;
    stage_ctrl_t   ctrl;
    logic          stall_inc;
    logic          redirect_inc;

    always_comb begin
        rs1_hit   = ID_use_rs1 && (ID_rs1 == ID_EX_rd);
        rs2_hit   = ID_use_rs2 && (ID_rs2 == ID_EX_rd);
        load_use  = ID_EX_memread && (ID_EX_rd != REG_ZERO) && (rs1_hit || rs2_hit);
        mem_stall = MEM_req && !dmem_ready;

        ctrl       = CTRL_IDLE;
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;

        case (state_q)
            ST_BOOT: begin
                ctrl = ctrl_boot();
                if (boot_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - BOOT_ONE;
                end
            end
            // RUN and MEM_WAIT share one priority chain; a released wait
            // falls straight through to redirect/load-use evaluation.
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    ctrl = ctrl_mem_stall();
                    if (state_q == ST_RUN) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WAIT_ONE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    if (EX_take) begin
                        ctrl = ctrl_redirect();
                    end else if (load_use) begin
                        ctrl = ctrl_bubble();
                    end
                end
            end
            ST_HALT: begin
                ctrl = ctrl_halt();
            end
            default: begin
                ctrl    = ctrl_halt();
                state_d = ST_HALT;
            end
        endcase

        stall_inc    = ctrl.pc_stall && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT));
        redirect_inc = ctrl.pc_redirect;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BOOT_INIT;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    hazard_sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    hazard_sat_counter #(.WIDTH(32)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_inc),
        .count (redirect_count)
    );

    assign PC_stall        = ctrl.pc_stall;
    assign IF_ID_stall     = ctrl.if_id_stall;
    assign IF_ID_flush     = ctrl.if_id_flush;
    assign EX_stall        = ctrl.ex_stall;
    assign ID_EX_flush     = ctrl.id_ex_flush;
    assign EX_MEM_stall    = ctrl.ex_mem_stall;
    assign EX_MEM_flush    = ctrl.ex_mem_flush;
    assign MEM_WB_flush    = ctrl.mem_wb_flush;
    assign pc_redirect     = ctrl.pc_redirect;
    assign halted          = ctrl.halted;
    assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed then randomized stimulus for hazard_ctrl, checked every cycle
// against a behavioural model of the sequencing rules.
module tb_hazard_ctrl;

    localparam int BOOT_CYCLES = 4;
    localparam int TIMEOUT     = 16;

    // Expected control vectors, ordered {PC_stall, IF_ID_stall, IF_ID_flush,
    // EX_stall, ID_EX_flush, EX_MEM_stall, EX_MEM_flush, MEM_WB_flush,
    // pc_redirect, halted}.
    localparam logic [9:0] V_IDLE   = 10'b00_0000_0000;
    localparam logic [9:0] V_BOOT   = 10'b10_1010_1100;
    localparam logic [9:0] V_MSTALL = 10'b11_0101_0100;
    localparam logic [9:0] V_HALT   = 10'b11_0101_0101;
    localparam logic [9:0] V_REDIR  = 10'b00_1010_0010;
    localparam logic [9:0] V_BUBBLE = 10'b11_0010_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs1, ID_rs2, ID_EX_rd;
    logic        ID_use_rs1, ID_use_rs2, ID_EX_memread;
    logic        EX_take, MEM_req, dmem_ready;
    logic        PC_stall, IF_ID_stall, IF_ID_flush, EX_stall, ID_EX_flush;
    logic        EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, pc_redirect, halted;
    logic        mem_timeout_err;
    logic [31:0] stall_cycles, redirect_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int      m_boot_left;
    int      m_wait_run;
    bit      m_halt;
    bit      m_err;
    longint  m_stalls;
    longint  m_redirs;

    hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_use_rs1      (ID_use_rs1),
        .ID_use_rs2      (ID_use_rs2),
        .ID_EX_memread   (ID_EX_memread),
        .ID_EX_rd        (ID_EX_rd),
        .EX_take         (EX_take),
        .MEM_req         (MEM_req),
        .dmem_ready      (dmem_ready),
        .PC_stall        (PC_stall),
        .IF_ID_stall     (IF_ID_stall),
        .IF_ID_flush     (IF_ID_flush),
        .EX_stall        (EX_stall),
        .ID_EX_flush     (ID_EX_flush),
        .EX_MEM_stall    (EX_MEM_stall),
        .EX_MEM_flush    (EX_MEM_flush),
        .MEM_WB_flush    (MEM_WB_flush),
        .pc_redirect     (pc_redirect),
        .halted          (halted),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles),
        .redirect_count  (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
        ID_EX_memread = 1'b0; ID_EX_rd = 5'd0;
        EX_take = 1'b0; MEM_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic model_reset();
        m_boot_left = BOOT_CYCLES;
        m_wait_run  = 0;
        m_halt      = 1'b0;
        m_err       = 1'b0;
        m_stalls    = 0;
        m_redirs    = 0;
    endtask

    function automatic longint sat_inc(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    // Called just after inputs change (between edges): predict, compare,
    // then advance the model to where the next rising edge will leave it.
    task automatic check_cycle(input string tag);
        logic [9:0] exp_v;
        logic [9:0] got_v;
        bit ms, lu;
        #1;
        ms    = MEM_req && !dmem_ready;
        lu    = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                ((ID_use_rs1 && (ID_rs1 == ID_EX_rd)) || (ID_use_rs2 && (ID_rs2 == ID_EX_rd)));
        exp_v = V_IDLE;
        if (reset) begin
            model_reset();
            exp_v = V_BOOT;
        end else if (m_halt) begin
            exp_v = V_HALT;
        end else if (m_boot_left > 0) begin
            exp_v = V_BOOT;
        end else if (ms) begin
            exp_v = V_MSTALL;
        end else if (EX_take) begin
            exp_v = V_REDIR;
        end else if (lu) begin
            exp_v = V_BUBBLE;
        end

        got_v = {PC_stall, IF_ID_stall, IF_ID_flush, EX_stall, ID_EX_flush,
                 EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, pc_redirect, halted};

        checks++;
        assert (got_v === exp_v) else begin
            failures++;
            $error("FAIL %s ctrl got=%b exp=%b", tag, got_v, exp_v);
        end
        checks++;
        assert (mem_timeout_err === m_err) else begin
            failures++;
            $error("FAIL %s timeout_err got=%b exp=%b", tag, mem_timeout_err, m_err);
        end
        checks++;
        assert (stall_cycles === 32'(m_stalls)) else begin
            failures++;
            $error("FAIL %s stall_cycles got=%0d exp=%0d", tag, stall_cycles, m_stalls);
        end
        checks++;
        assert (redirect_count === 32'(m_redirs)) else begin
            failures++;
            $error("FAIL %s redirect_count got=%0d exp=%0d", tag, redirect_count, m_redirs);
        end
        $display("cycle %-10s ctrl=%b err=%b stalls=%0d redirs=%0d",
                 tag, got_v, mem_timeout_err, stall_cycles, redirect_count);

        if (!reset) begin
            if (m_halt) begin
                // held until reset
            end else if (m_boot_left > 0) begin
                m_boot_left--;
            end else if (ms) begin
                m_stalls = sat_inc(m_stalls);
                m_wait_run++;
                if (m_wait_run == TIMEOUT) begin
                    m_halt = 1'b1;
                    m_err  = 1'b1;
                end
            end else begin
                m_wait_run = 0;
                if (EX_take) m_redirs = sat_inc(m_redirs);
                else if (lu) m_stalls = sat_inc(m_stalls);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_cycle("reset");
        reset = 1'b0;

        // Boot window then idle
        for (int i = 0; i < BOOT_CYCLES + 1; i++) check_cycle("boot");

        // Load-use on rs2, then the bubble clears it
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5; ID_use_rs2 = 1'b1;
        check_cycle("loaduse");
        ID_EX_memread = 1'b0;
        check_cycle("lu_clear");

        // Load into x0 never stalls
        set_idle();
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd0; ID_rs1 = 5'd0; ID_use_rs1 = 1'b1;
        check_cycle("lu_x0");

        // Redirect beats load-use
        set_idle();
        ID_EX_memread = 1'b1; ID_EX_rd = 5'd7; ID_rs1 = 5'd7; ID_use_rs1 = 1'b1;
        EX_take = 1'b1;
        check_cycle("redir_lu");

        // Three wait cycles with EX_take held, then ready
        set_idle();
        EX_take = 1'b1; MEM_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) check_cycle("memwait");
        dmem_ready = 1'b1;
        check_cycle("mem_ready");
        set_idle();
        check_cycle("idle");

        // Watchdog timeout into HALT
        MEM_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < TIMEOUT + 3; i++) check_cycle("timeout");
        set_idle();
        EX_take = 1'b1;
        check_cycle("halt_in");
        set_idle();

        // Reset asserted mid-HALT, away from a clock edge
        reset = 1'b1;
        check_cycle("halt_rst");
        reset = 1'b0;
        for (int i = 0; i < BOOT_CYCLES + 1; i++) check_cycle("reboot");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            ID_rs1        = 5'($urandom_range(0, 3));
            ID_rs2        = 5'($urandom_range(0, 3));
            ID_use_rs1    = 1'($urandom_range(0, 1));
            ID_use_rs2    = 1'($urandom_range(0, 1));
            ID_EX_memread = 1'($urandom_range(0, 1));
            ID_EX_rd      = 5'($urandom_range(0, 3));
            EX_take       = ($urandom_range(0, 4) == 0);
            MEM_req       = 1'($urandom_range(0, 1));
            dmem_ready    = ($urandom_range(0, 3) != 0);
            check_cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
